noc_local_pkt_buffer: RTL and testbench
=======================================

# noc_local_pkt_buffer

Store-and-forward packet buffer between the tile switch local output port and a tile accelerator's stream input. It accepts AXI-stream flits from the switch, checks the destination field of each packet header against the tile's own ID, and holds each packet until its last flit has arrived. Only complete, correctly addressed packets are released downstream; misaddressed and oversize packets are discarded and counted.

## Interface
Parameters:
- BW, 32, flit data width
- BWB, BW/8, keep width
- XY_SZ, 3, width of one tile coordinate
- DEPTH_LOG2, 4, log2 of buffer depth in flits (default 16)

Ports:
- clk_line  in  1  line clock; the block's only clock
- clk_line_rst_high  in  1  asynchronous, active-high reset
- HsrcId  in  2*XY_SZ  own tile ID {Y,X}; static after reset
- stream_in_TVALID / TDATA / TKEEP / TLAST  in  1 / BW / BWB / 1  flits from switch local output
- stream_in_TREADY  out  1  ingress ready
- stream_out_TVALID / TDATA / TKEEP / TLAST  out  1 / BW / BWB / 1  flits to accelerator
- stream_out_TREADY  in  1  egress ready
- drop_count  out  16  number of discarded packets, saturating
- oversize_err  out  1  sticky; set when a packet longer than the buffer was discarded

## Operation
- Header: first flit of every packet. TDATA[2*XY_SZ-1:0] is the destination ID.
- Storage: 2**DEPTH_LOG2 entries of {TLAST, TKEEP, TDATA}.
- Pointers: wr_ptr, wr_commit and rd_ptr, each DEPTH_LOG2+1 bits wide, with natural wrap.
- Derived terms:
  - used = wr_ptr - rd_ptr
  - full = (used == 2**DEPTH_LOG2)
  - egress data present when rd_ptr != wr_commit
- Write FSM states: HDR, BODY, DISCARD.
  - HDR, flit accepted, destination == HsrcId:
    - Write the flit, wr_ptr++.
    - If TLAST=1, wr_commit takes the new wr_ptr and the FSM stays in HDR. Otherwise go to BODY.
  - HDR, flit accepted, destination mismatch:
    - Do not write the flit.
    - If TLAST=1, drop_count++ and stay in HDR. Otherwise go to DISCARD.
  - BODY, flit accepted:
    - Write the flit, wr_ptr++.
    - If TLAST=1, commit (wr_commit takes the new wr_ptr) and go to HDR.
  - BODY, full and wr_commit == rd_ptr (the uncommitted packet fills the whole buffer):
    - wr_ptr returns to wr_commit, oversize_err is set, and the FSM goes to DISCARD.
  - DISCARD:
    - Accept flits and discard them.
    - On TLAST, drop_count++ and go to HDR.
- stream_in_TREADY:
  - 1 in HDR or BODY when not full.
  - 0 when full and committed data is pending (backpressure).
  - Always 1 in DISCARD.
- Egress:
  - stream_out_TVALID = (rd_ptr != wr_commit).
  - TDATA, TKEEP and TLAST are read combinationally from entry rd_ptr.
  - rd_ptr++ on TVALID & TREADY.
- drop_count saturates at 16'hFFFF.
- Simultaneous read and write in one cycle is legal; full is evaluated on the pre-edge pointers.

## Timing
- Reset values (while reset asserted and on release):
  - All pointers 0, FSM in HDR.
  - stream_out_TVALID=0, drop_count=0, oversize_err=0.
  - stream_in_TREADY=1.
  - Entry contents are don't-care.
- Reset mid-packet: any partially received packet and all buffered packets are lost. The upstream source must restart from a header.
- Latency: a flit accepted at edge N with TLAST=1 makes stream_out_TVALID=1 from cycle N+1. No cut-through.
- Throughput: 1 flit/cycle on each side independently.
- AXI-stream rules on egress: TVALID, once asserted, is held until accepted, and TDATA, TKEEP and TLAST stay stable while TVALID=1 and TREADY=0.
- A freed slot raises stream_in_TREADY in the cycle after the egress handshake.

## Test plan
- **3-flit packet:** header destination 6'h0A with HsrcId=6'h0A, stream_out_TREADY=1 -> 3 identical flits out, in order. TVALID first rises 1 cycle after the TLAST handshake. drop_count=0.
- **Misaddressed 2-flit packet:** destination 6'h03 with HsrcId=6'h0A -> no egress. TREADY held at 1. drop_count=1.
- **Oversize:** DEPTH_LOG2=4, matched 20-flit packet, then a matched 2-flit packet -> first packet is not delivered, oversize_err=1, drop_count=1, and the 2-flit packet is delivered intact.
- **Backpressure:** stream_out_TREADY=0, four matched 4-flit packets, then a fifth -> 16 flits held and stream_in_TREADY=0 while the fifth header is presented. Releasing TREADY delivers all 20 flits in order with no loss.
- **Single-flit packet:** matched header with TLAST=1 -> one flit out with TLAST=1, and the FSM remains in HDR.
- **Reset mid-packet:** assert reset after 2 of 4 flits, then send a fresh 3-flit packet -> TVALID=0 during reset, and only the fresh packet is delivered.

Source files
------------

// File: rtl/noc_local_pkt_buffer_if.sv
// AXI-stream style flit channel shared by the switch side and the accelerator side.
interface noc_local_pkt_buffer_if #(
  parameter int BW  = 32,
  parameter int BWB = BW / 8
);
  logic           TVALID;
  logic [BW-1:0]  TDATA;
  logic [BWB-1:0] TKEEP;
  logic           TLAST;
  logic           TREADY;

  modport master (output TVALID, TDATA, TKEEP, TLAST, input TREADY);
  modport slave  (input TVALID, TDATA, TKEEP, TLAST, output TREADY);
endinterface

// File: rtl/noc_local_pkt_buffer.sv
// Store-and-forward packet buffer between the tile switch local port and the
// accelerator stream input. Packets are written behind an uncommitted write
// pointer and only become visible to egress once their last flit has landed.
// Misaddressed packets and packets larger than the buffer are discarded.
module noc_local_pkt_buffer #(
  parameter int BW         = 32,
  parameter int BWB        = BW / 8,
  parameter int XY_SZ      = 3,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                   clk_line,
  input  logic                   clk_line_rst_high,
  input  logic [2*XY_SZ-1:0]     HsrcId,
  noc_local_pkt_buffer_if.slave  stream_in,
  noc_local_pkt_buffer_if.master stream_out,
  output logic [15:0]            drop_count,
  output logic                   oversize_err
);

  localparam int               DEPTH   = 1 << DEPTH_LOG2;
  localparam int               PW      = DEPTH_LOG2 + 1;
  localparam int               EW      = 1 + BWB + BW;
  localparam logic [PW-1:0]    DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0]    PTR_ONE = PW'(1);

  typedef enum logic [1:0] {
    S_HDR     = 2'd0,
    S_BODY    = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   wr_commit_q, wr_commit_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [15:0]     drop_count_q, drop_count_d;
  logic            oversize_q, oversize_d;

  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   rd_entry;

  logic [PW-1:0]   used;
  logic            full;
  logic            abort;
  logic            in_ready;
  logic            in_fire;
  logic            dst_match;
  logic            out_valid;
  logic            out_fire;
  logic            wr_en;

  // Saturating increment for the drop counter
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Occupancy, flow-control and handshake terms from the pre-edge pointers
  always_comb begin
    used      = wr_ptr_q - rd_ptr_q;
    full      = (used == DEPTH_P);
    // The in-flight packet alone fills the buffer: it can never complete.
    abort     = (state_q == S_BODY) && full && (wr_commit_q == rd_ptr_q);
    in_ready  = (state_q == S_DISCARD) || !full;
    in_fire   = stream_in.TVALID && in_ready;
    dst_match = (stream_in.TDATA[2*XY_SZ-1:0] == HsrcId);
    out_valid = (rd_ptr_q != wr_commit_q);
    out_fire  = out_valid && stream_out.TREADY;
  end

  // Write-side packet FSM and pointer/counter next-state
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    wr_commit_d  = wr_commit_q;
    rd_ptr_d     = out_fire ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    drop_count_d = drop_count_q;
    oversize_d   = oversize_q;
    wr_en        = 1'b0;

    case (state_q)
      S_HDR: begin
        if (in_fire) begin
          if (dst_match) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (stream_in.TLAST) begin
              wr_commit_d = wr_ptr_q + PTR_ONE;
            end else begin
              state_d = S_BODY;
            end
          end else begin
            if (stream_in.TLAST) begin
              drop_count_d = sat_inc16(drop_count_q);
            end else begin
              state_d = S_DISCARD;
            end
          end
        end
      end

      S_BODY: begin
        if (abort) begin
          // Roll back the partial packet and swallow the rest of it.
          wr_ptr_d   = wr_commit_q;
          oversize_d = 1'b1;
          state_d    = S_DISCARD;
        end else if (in_fire) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          if (stream_in.TLAST) begin
            wr_commit_d = wr_ptr_q + PTR_ONE;
            state_d     = S_HDR;
          end
        end
      end

      S_DISCARD: begin
        if (in_fire && stream_in.TLAST) begin
          drop_count_d = sat_inc16(drop_count_q);
          state_d      = S_HDR;
        end
      end

      default: begin
        state_d = S_HDR;
      end
    endcase
  end

  // Control state: FSM, pointers and status, cleared by reset
  always_ff @(posedge clk_line or posedge clk_line_rst_high) begin
    if (clk_line_rst_high) begin
      state_q      <= S_HDR;
      wr_ptr_q     <= '0;
      wr_commit_q  <= '0;
      rd_ptr_q     <= '0;
      drop_count_q <= '0;
      oversize_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      wr_commit_q  <= wr_commit_d;
      rd_ptr_q     <= rd_ptr_d;
      drop_count_q <= drop_count_d;
      oversize_q   <= oversize_d;
    end
  end

  // Flit storage; contents are don't-care after reset so no reset here
  always_ff @(posedge clk_line) begin
    if (wr_en) begin
      mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= {stream_in.TLAST, stream_in.TKEEP, stream_in.TDATA};
    end
  end

  assign rd_entry = mem[rd_ptr_q[DEPTH_LOG2-1:0]];

  assign stream_in.TREADY  = in_ready;
  assign stream_out.TVALID = out_valid;
  assign stream_out.TDATA  = rd_entry[BW-1:0];
  assign stream_out.TKEEP  = rd_entry[BW+BWB-1:BW];
  assign stream_out.TLAST  = rd_entry[EW-1];

  assign drop_count   = drop_count_q;
  assign oversize_err = oversize_q;

  a_used_bound: assert property (@(posedge clk_line) disable iff (clk_line_rst_high)
                                 used <= DEPTH_P);

endmodule

// File: tb/tb_noc_local_pkt_buffer.sv
// Randomized bench for noc_local_pkt_buffer with a packet-level reference model.
module tb_noc_local_pkt_buffer;
  localparam int BW         = 32;
  localparam int BWB        = 4;
  localparam int XY_SZ      = 3;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;
  localparam logic [5:0] MY_ID = 6'h0A;

  typedef logic [BW+BWB:0] flit_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  hsrc = MY_ID;
  logic [15:0] drop_count;
  logic        oversize_err;

  noc_local_pkt_buffer_if #(.BW(BW), .BWB(BWB)) s_in ();
  noc_local_pkt_buffer_if #(.BW(BW), .BWB(BWB)) s_out ();

  noc_local_pkt_buffer #(
    .BW(BW), .BWB(BWB), .XY_SZ(XY_SZ), .DEPTH_LOG2(DEPTH_LOG2)
  ) dut (
    .clk_line          (clk),
    .clk_line_rst_high (rst),
    .HsrcId            (hsrc),
    .stream_in         (s_in),
    .stream_out        (s_out),
    .drop_count        (drop_count),
    .oversize_err      (oversize_err)
  );

  always #5 clk = ~clk;

  // Reference model state
  flit_t tx_q[$];
  flit_t exp_q[$];
  flit_t part_q[$];
  int    mode;        // 0 waiting header, 1 keeping packet body, 2 discarding
  int    m_drops;
  bit    m_over;
  flit_t cur;
  bit    cur_v;
  int    rdy_pct;
  int    vld_pct;
  int    n_chk;
  int    n_fail;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    tx_q.delete();
    exp_q.delete();
    part_q.delete();
    mode    = 0;
    m_drops = 0;
    m_over  = 1'b0;
    cur_v   = 1'b0;
  endtask

  task automatic add_pkt(input logic [5:0] dst, input int len, input int nsend);
    flit_t f;
    for (int i = 0; i < nsend; i++) begin
      f[BW-1:0] = $urandom();
      if (i == 0) f[5:0] = dst;
      f[BW+BWB-1:BW] = 4'($urandom_range(1, 15));
      f[BW+BWB]      = (i == len - 1);
      tx_q.push_back(f);
    end
  endtask

  task automatic model_accept(input flit_t f);
    bit last;
    last = f[BW+BWB];
    case (mode)
      0: begin
        if (f[5:0] == MY_ID) begin
          part_q.push_back(f);
          if (last) begin
            while (part_q.size() != 0) exp_q.push_back(part_q.pop_front());
          end else begin
            mode = 1;
          end
        end else if (last) begin
          if (m_drops < 65535) m_drops++;
        end else begin
          mode = 2;
        end
      end
      1: begin
        part_q.push_back(f);
        if (last) begin
          while (part_q.size() != 0) exp_q.push_back(part_q.pop_front());
          mode = 0;
        end
      end
      default: begin
        if (last) begin
          if (m_drops < 65535) m_drops++;
          mode = 0;
        end
      end
    endcase
  endtask

  // One clock of stimulus and checking, performed on the falling edge
  task automatic step();
    int    committed;
    int    occ;
    bit    exp_rdy;
    flit_t f;
    @(negedge clk);
    committed = exp_q.size();
    occ       = committed + part_q.size();
    check_eq("out_tvalid", 64'(s_out.TVALID), 64'(committed != 0));
    check_eq("drop_count", 64'(drop_count), 64'(m_drops));
    check_eq("oversize_err", 64'(oversize_err), 64'(m_over));

    s_out.TREADY = (int'($urandom_range(99)) < rdy_pct);
    if (s_out.TVALID && s_out.TREADY) begin
      if (exp_q.size() == 0) begin
        check_eq("egress_unexpected", 64'(s_out.TVALID), 64'(0));
      end else begin
        f = exp_q.pop_front();
        check_eq("egress_flit", 64'({s_out.TLAST, s_out.TKEEP, s_out.TDATA}), 64'(f));
      end
    end

    // A packet that has filled the whole buffer by itself is abandoned now.
    if (mode == 1 && occ == DEPTH && committed == 0) begin
      part_q.delete();
      m_over  = 1'b1;
      mode    = 2;
      exp_rdy = 1'b0;
    end else begin
      exp_rdy = (mode == 2) || (occ < DEPTH);
    end

    if (!cur_v && !rst && tx_q.size() != 0 && int'($urandom_range(99)) < vld_pct) begin
      cur   = tx_q.pop_front();
      cur_v = 1'b1;
    end
    s_in.TVALID = cur_v;
    if (cur_v) begin
      {s_in.TLAST, s_in.TKEEP, s_in.TDATA} = cur;
    end else begin
      s_in.TDATA = $urandom();
      s_in.TKEEP = 4'($urandom());
      s_in.TLAST = 1'($urandom());
    end
    check_eq("in_tready", 64'(s_in.TREADY), 64'(exp_rdy));
    if (cur_v && s_in.TREADY) begin
      model_accept(cur);
      cur_v = 1'b0;
    end
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while ((tx_q.size() != 0 || cur_v || exp_q.size() != 0) && c < budget) begin
      step();
      c++;
    end
    check_eq("drain_done", 64'(tx_q.size() + int'(cur_v) + exp_q.size()), 64'(0));
  endtask

  task automatic send_only(input int budget);
    int c;
    c = 0;
    while ((tx_q.size() != 0 || cur_v) && c < budget) begin
      step();
      c++;
    end
    check_eq("send_done", 64'(tx_q.size() + int'(cur_v)), 64'(0));
  endtask

  initial begin
    logic [5:0] bad;
    int         len;
    n_chk   = 0;
    n_fail  = 0;
    rdy_pct = 100;
    vld_pct = 100;
    model_reset();
    s_in.TVALID  = 1'b0;
    s_in.TDATA   = '0;
    s_in.TKEEP   = '0;
    s_in.TLAST   = 1'b0;
    s_out.TREADY = 1'b0;

    // Reset values
    run_n(3);
    check_eq("rst_tready", 64'(s_in.TREADY), 64'(1));
    rst = 1'b0;
    run_n(2);

    // Matched 3-flit packet
    add_pkt(MY_ID, 3, 3);
    drain(100);
    check_eq("p3_drops", 64'(drop_count), 64'(0));

    // Misaddressed 2-flit packet
    add_pkt(6'h03, 2, 2);
    drain(100);
    run_n(1);
    check_eq("mis_drops", 64'(drop_count), 64'(1));

    // Oversize packet followed by a deliverable one
    add_pkt(MY_ID, 20, 20);
    add_pkt(MY_ID, 2, 2);
    drain(200);
    run_n(1);
    check_eq("ovs_flag", 64'(oversize_err), 64'(1));
    check_eq("ovs_drops", 64'(drop_count), 64'(2));

    // Backpressure: five 4-flit packets with egress stalled
    rdy_pct = 0;
    for (int p = 0; p < 5; p++) add_pkt(MY_ID, 4, 4);
    run_n(40);
    check_eq("bp_tready", 64'(s_in.TREADY), 64'(0));
    check_eq("bp_held", 64'(s_out.TVALID), 64'(1));
    rdy_pct = 100;
    drain(200);

    // Single-flit packets back to back
    add_pkt(MY_ID, 1, 1);
    add_pkt(MY_ID, 1, 1);
    add_pkt(MY_ID, 2, 2);
    drain(100);

    // Randomized traffic
    for (int blk = 0; blk < 10; blk++) begin
      rdy_pct = $urandom_range(30, 100);
      vld_pct = $urandom_range(40, 100);
      for (int p = 0; p < 30; p++) begin
        len = ($urandom_range(9) == 0) ? $urandom_range(14, 20) : $urandom_range(1, 8);
        if ($urandom_range(3) == 0) begin
          bad = 6'($urandom());
          if (bad == MY_ID) bad = bad ^ 6'h01;
          add_pkt(bad, len, len);
        end else begin
          add_pkt(MY_ID, len, len);
        end
      end
      drain(6000);
    end
    rdy_pct = 100;
    vld_pct = 100;

    // Reset with a buffered packet and a half-received one
    rdy_pct = 0;
    add_pkt(MY_ID, 3, 3);
    add_pkt(MY_ID, 4, 2);
    send_only(100);
    run_n(1);
    rst = 1'b1;
    model_reset();
    run_n(3);
    check_eq("midrst_tvalid", 64'(s_out.TVALID), 64'(0));
    check_eq("midrst_tready", 64'(s_in.TREADY), 64'(1));
    rst = 1'b0;
    rdy_pct = 100;
    add_pkt(MY_ID, 3, 3);
    drain(100);
    run_n(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Absolute time limit so the run always terminates
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
